serial_deserializer: RTL and testbench
======================================

Name: serial_deserializer

Overview:
- Receive-side counterpart of the team's universal shift register.
- Accepts the serial bit stream that register shifts out (via q[Width-1] on shift-left, or q[0] on shift-right) and rebuilds WIDTH-bit parallel words.
- Presents each word on a registered valid/ready output port.
- Sits at the far end of a serial link, between the link pin and a parallel consumer.

Parameters:
- WIDTH, 4, word width in bits (>= 2).
- CNT_W, $clog2(WIDTH+1), width of bit counter (derived, not overridden).

Ports:
- clk  input  1  rising-edge clock.
- clr  input  1  synchronous active-high reset.
- s_in  input  1  serial data bit.
- s_valid  input  1  s_in holds a valid bit this cycle.
- dir  input  1  bit order: 0 = MSB first (matches shift-left sender), 1 = LSB first (matches shift-right sender).
- abort  input  1  discard partially received word.
- q_out  output  WIDTH  assembled word.
- q_valid  output  1  q_out holds an unconsumed word.
- q_ready  input  1  consumer accepts q_out this cycle.
- busy  output  1  partial word in progress (bit_cnt != 0).
- bit_cnt  output  CNT_W  bits received in current word.
- overrun  output  1  sticky: a completed word was dropped.

Behaviour:
- Reset (clr=1 at posedge) has the highest priority. It forces:
  - q_out=0, q_valid=0, busy=0, bit_cnt=0, overrun=0.
  - Shift accumulator = 0, FSM = IDLE.
- FSM states:
  - IDLE (bit_cnt=0).
  - SHIFT (0 < bit_cnt < WIDTH).
- IDLE -> SHIFT on s_valid. dir is latched into an internal order flag on this first bit and held for the whole word. A dir change mid-word is ignored.
- Each accepted bit (s_valid=1):
  - Order 0: acc <= {acc[WIDTH-2:0], s_in}.
  - Order 1: acc <= {s_in, acc[WIDTH-1:1]}.
  - bit_cnt increments by 1.
- Word completion: s_valid on the bit with bit_cnt == WIDTH-1.
  - Assembled word (including this bit) is the completion candidate.
  - bit_cnt <= 0, FSM -> IDLE, all in the same edge.
- Output register, evaluated at each posedge:
  - Completion and (q_valid=0 or q_ready=1): q_out <= candidate, q_valid <= 1. A same-cycle handshake plus new word keeps q_valid at 1 with no gap and no overrun.
  - Completion, q_valid=1 and q_ready=0: candidate dropped, q_out unchanged, overrun <= 1.
  - No completion and q_ready=1: q_valid <= 0. q_out holds its last value.
- Latency: q_valid rises on the clock edge that samples the final bit, so it is visible the following cycle.
- q_out is stable while q_valid=1 and q_ready=0.
- overrun stays set until clr.
- abort=1 (clr=0):
  - acc <= 0, bit_cnt <= 0, FSM -> IDLE.
  - s_valid is ignored that cycle; the bit is not taken as the first bit of a new word.
  - Output register and overrun are unaffected. A q_ready handshake that cycle still completes.
- s_valid=0: no state change in the input side. Gaps between bits of any length are allowed.
- busy = (bit_cnt != 0), driven from registered state.
- The consumer may hold q_ready=1 continuously, giving one word per WIDTH bits with zero stall.

Optional Feature:
- Macro: DESER_PARITY_EN.
- Defined:
  - Each word is WIDTH data bits followed by one even-parity bit, so completion occurs at bit_cnt == WIDTH.
  - CNT_W covers WIDTH+1.
  - The parity bit is not stored in q_out.
  - Extra output parity_err (1 bit) is registered alongside q_out. It is 1 when XOR of data and parity bits = 1, and is valid while q_valid=1.
  - On reset parity_err = 0.
  - A dropped (overrun) word does not update parity_err.
- Undefined: no parity bit, no parity_err port, word completes after WIDTH bits.

Decomposition:
- Shared package: FSM state encoding (ST_IDLE=1'b0, ST_SHIFT=1'b1) and bit-order constants (ORD_MSB_FIRST=0, ORD_LSB_FIRST=1).
- One natural sub-module, deser_out_reg: the output holding register with its valid/ready/overrun logic. The top holds the FSM, accumulator and counter.

Test Plan:
- Reset check: clr high for 2 cycles -> q_out=0, q_valid=0, busy=0, bit_cnt=0, overrun=0.
- MSB-first word: dir=0, bits 1,0,1,1 on consecutive cycles, q_ready=1 -> q_out=4'b1011, q_valid=1 for exactly 1 cycle, starting the cycle after the 4th bit.
- LSB-first word with gaps: dir=1, bits 1,0,1,1 with idle cycles between them, and dir toggled after the first bit -> q_out=4'b1101 and busy high throughout.
- Overrun and back-to-back: q_ready=0, send 4'hA then 4'h5 MSB-first -> q_out stays 4'hA and overrun=1. Then assert q_ready on the same cycle the next word 4'h3 completes -> q_out=4'h3, q_valid remains 1.
- Abort: send 2 bits, pulse abort with s_valid=1 -> bit_cnt=0 and that bit is discarded. The next 4 bits 0,1,1,0 -> q_out=4'b0110.
- DESER_PARITY_EN: send 1,0,1,1 then parity 1 -> parity_err=0. Send 1,0,1,1 then 0 -> parity_err=1 with q_out=4'b1011.

Source files
------------

// File: rtl/serial_deserializer_pkg.sv
// +----------------------------------------------------------------------------+
// | Module  : serial_deserializer_pkg                                          |
// | Brief   : Shared FSM encoding and bit-order constants for the deserializer.|
// |           Optional macro DESER_PARITY_EN adds one even-parity bit per word.|
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

package serial_deserializer_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  localparam logic ORD_MSB_FIRST = 1'b0;
  localparam logic ORD_LSB_FIRST = 1'b1;

`ifdef DESER_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif

endpackage

`default_nettype wire

// File: rtl/serial_deserializer_out_reg.sv
// +----------------------------------------------------------------------------+
// | Module  : deser_out_reg                                                    |
// | Brief   : Valid/ready output holding register with sticky overrun flag.    |
// |           Optional macro DESER_PARITY_EN carries a parity-error bit.       |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module deser_out_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             i_wr,
  input  logic [WIDTH-1:0] i_data,
`ifdef DESER_PARITY_EN
  input  logic             i_perr,
  output logic             o_perr,
`endif
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic             o_overrun
);

  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic             r_overrun;
`ifdef DESER_PARITY_EN
  logic             r_perr;
`endif

  // A new word may replace the held one only when the slot is empty or being consumed now.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
`ifdef DESER_PARITY_EN
      r_perr    <= 1'b0;
`endif
    end else if (i_wr && (!r_valid || i_ready)) begin
      r_data  <= i_data;
      r_valid <= 1'b1;
`ifdef DESER_PARITY_EN
      r_perr  <= i_perr;
`endif
    end else if (i_wr) begin
      r_overrun <= 1'b1;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_data    = r_data;
  assign o_valid   = r_valid;
  assign o_overrun = r_overrun;
`ifdef DESER_PARITY_EN
  assign o_perr    = r_perr;
`endif

endmodule

`default_nettype wire

// File: rtl/serial_deserializer.sv
// +----------------------------------------------------------------------------+
// | Module  : serial_deserializer                                              |
// | Brief   : Rebuilds WIDTH-bit words from a serial stream, MSB or LSB first. |
// |           Optional macro DESER_PARITY_EN: trailing even-parity bit/word.   |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module serial_deserializer
  import serial_deserializer_pkg::*;
#(
  parameter  int WIDTH = 4,
  localparam int CNT_W = $clog2(WIDTH + 1 + PARITY_BITS)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             s_in,
  input  logic             s_valid,
  input  logic             dir,
  input  logic             abort,
  output logic [WIDTH-1:0] q_out,
  output logic             q_valid,
  input  logic             q_ready,
  output logic             busy,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             overrun
`ifdef DESER_PARITY_EN
  ,
  output logic             parity_err
`endif
);

  localparam int             c_nbits = WIDTH + PARITY_BITS;
  localparam logic [CNT_W-1:0] c_last  = CNT_W'(c_nbits - 1);

  state_t           r_state;
  logic             r_order;
  logic [WIDTH-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;

  state_t           w_state_nxt;
  logic             w_order_nxt;
  logic [WIDTH-1:0] w_acc_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_order_eff;
  logic [WIDTH-1:0] w_acc_shift;
  logic             w_is_data;
  logic             w_complete;
  logic [WIDTH-1:0] w_cand;
`ifdef DESER_PARITY_EN
  logic             w_perr;
`endif

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state <= ST_IDLE;
      r_order <= ORD_MSB_FIRST;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_order <= w_order_nxt;
      r_acc   <= w_acc_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // The first bit of a word takes its order from dir directly; later bits use the latched flag.
  always_comb begin
    w_order_eff = (r_state == ST_IDLE) ? dir : r_order;
    w_acc_shift = (w_order_eff == ORD_MSB_FIRST) ? {r_acc[WIDTH-2:0], s_in}
                                                 : {s_in, r_acc[WIDTH-1:1]};
`ifdef DESER_PARITY_EN
    w_is_data   = (r_cnt < CNT_W'(WIDTH));
    w_cand      = r_acc;
    w_perr      = (^r_acc) ^ s_in;
`else
    w_is_data   = 1'b1;
    w_cand      = w_acc_shift;
`endif
  end

  always_comb begin
    w_state_nxt = r_state;
    w_order_nxt = r_order;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    w_complete  = 1'b0;
    if (abort) begin
      w_state_nxt = ST_IDLE;
      w_acc_nxt   = '0;
      w_cnt_nxt   = '0;
    end else if (s_valid) begin
      w_order_nxt = w_order_eff;
      if (w_is_data) begin
        w_acc_nxt = w_acc_shift;
      end
      case (r_state)
        ST_IDLE: begin
          w_state_nxt = ST_SHIFT;
          w_cnt_nxt   = CNT_W'(1);
        end
        ST_SHIFT: begin
          if (r_cnt == c_last) begin
            w_complete  = 1'b1;
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  deser_out_reg #(
    .WIDTH(WIDTH)
  ) u_out_reg (
    .clk      (clk),
    .clr      (clr),
    .i_wr     (w_complete),
    .i_data   (w_cand),
`ifdef DESER_PARITY_EN
    .i_perr   (w_perr),
    .o_perr   (parity_err),
`endif
    .i_ready  (q_ready),
    .o_data   (q_out),
    .o_valid  (q_valid),
    .o_overrun(overrun)
  );

  assign bit_cnt = r_cnt;
  assign busy    = (r_cnt != '0);

endmodule

`default_nettype wire

// File: tb/tb_serial_deserializer.sv
// +----------------------------------------------------------------------------+
// | Module  : tb_serial_deserializer                                           |
// | Brief   : Self-checking bench: vector table, directed corners, random run. |
// |           Honours DESER_PARITY_EN when defined.                            |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_serial_deserializer;

  localparam int W = 4;
`ifdef DESER_PARITY_EN
  localparam int NB = W + 1;
`else
  localparam int NB = W;
`endif

  logic         clk = 1'b0;
  logic         clr = 1'b1;
  logic         s_in = 1'b0;
  logic         s_valid = 1'b0;
  logic         dir = 1'b0;
  logic         abort = 1'b0;
  logic         q_ready = 1'b0;
  logic [W-1:0] q_out;
  logic         q_valid;
  logic         busy;
  logic [2:0]   bit_cnt;
  logic         overrun;
`ifdef DESER_PARITY_EN
  logic         parity_err;
`endif

  int n_checks = 0;
  int n_err    = 0;

  serial_deserializer #(.WIDTH(W)) dut (
    .clk       (clk),
    .clr       (clr),
    .s_in      (s_in),
    .s_valid   (s_valid),
    .dir       (dir),
    .abort     (abort),
    .q_out     (q_out),
    .q_valid   (q_valid),
    .q_ready   (q_ready),
    .busy      (busy),
    .bit_cnt   (bit_cnt),
    .overrun   (overrun)
`ifdef DESER_PARITY_EN
    ,
    .parity_err(parity_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] seq;   // seq[W-1] is transmitted first
    logic         d;
    int           gap;
    logic [W-1:0] exp;
  } vec_t;

  vec_t vecs[8];

  // reference model state
  logic         m_bits[$];
  logic         m_ord;
  logic [W-1:0] m_q;
  logic         m_v;
  logic         m_ovr;
  logic         m_perr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic d);
    s_valid = 1'b1;
    s_in    = b;
    dir     = d;
    tick();
    s_valid = 1'b0;
    s_in    = 1'b0;
  endtask

  task automatic send_data(input logic [W-1:0] seq, input logic d, input int gap, input logic toggle);
    for (int i = W - 1; i >= 0; i--) begin
      send_bit(seq[i], (toggle && i != W - 1) ? ~d : d);
      if (i != 0) begin
        for (int g = 0; g < gap; g++) begin
          tick();
          chk("busy_gap", busy, 1);
        end
      end
    end
`ifdef DESER_PARITY_EN
    send_bit(^seq, d);
`endif
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{4'b1011, 1'b0, 0, 4'b1011};
    vecs[1] = '{4'b1011, 1'b1, 0, 4'b1101};
    vecs[2] = '{4'b1000, 1'b1, 1, 4'b0001};
    vecs[3] = '{4'b0001, 1'b0, 2, 4'b0001};
    vecs[4] = '{4'b1110, 1'b1, 0, 4'b0111};
    vecs[5] = '{4'b1111, 1'b0, 3, 4'b1111};
    vecs[6] = '{4'b0000, 1'b1, 0, 4'b0000};
    vecs[7] = '{4'b0110, 1'b1, 1, 4'b0110};

    // reset
    clr = 1'b1;
    tick();
    tick();
    chk("rst_q_out", q_out, 0);
    chk("rst_q_valid", q_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_bit_cnt", bit_cnt, 0);
    chk("rst_overrun", overrun, 0);
`ifdef DESER_PARITY_EN
    chk("rst_parity_err", parity_err, 0);
`endif
    clr = 1'b0;

    // MSB-first, valid for exactly one cycle
    q_ready = 1'b1;
    send_data(4'b1011, 1'b0, 0, 1'b0);
    chk("msb_q_valid", q_valid, 1);
    chk("msb_q_out", q_out, 4'b1011);
    tick();
    chk("msb_q_valid_drop", q_valid, 0);

    // LSB-first with gaps, dir toggled after the first bit
    send_data(4'b1011, 1'b1, 2, 1'b1);
    chk("lsb_q_valid", q_valid, 1);
    chk("lsb_q_out", q_out, 4'b1101);
    tick();

    // vector table
    for (int v = 0; v < 8; v++) begin
      send_data(vecs[v].seq, vecs[v].d, vecs[v].gap, 1'b0);
      chk("tbl_q_valid", q_valid, 1);
      chk("tbl_q_out", q_out, vecs[v].exp);
      tick();
      chk("tbl_q_valid_drop", q_valid, 0);
    end

    // overrun, then handshake on the completing cycle
    q_ready = 1'b0;
    send_data(4'hA, 1'b0, 0, 1'b0);
    chk("ovr_first_valid", q_valid, 1);
    chk("ovr_first_q", q_out, 4'hA);
    chk("ovr_not_yet", overrun, 0);
    send_data(4'h5, 1'b0, 0, 1'b0);
    chk("ovr_held_q", q_out, 4'hA);
    chk("ovr_flag", overrun, 1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
`ifdef DESER_PARITY_EN
    send_bit(1'b1, 1'b0);
    q_ready = 1'b1;
    send_bit(1'b0, 1'b0);
`else
    q_ready = 1'b1;
    send_bit(1'b1, 1'b0);
`endif
    chk("b2b_q_out", q_out, 4'h3);
    chk("b2b_q_valid", q_valid, 1);
    chk("b2b_overrun_sticky", overrun, 1);
    tick();
    chk("b2b_drained", q_valid, 0);

    // abort discards the partial word and the bit presented with it
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    chk("abort_pre_cnt", bit_cnt, 2);
    abort   = 1'b1;
    s_valid = 1'b1;
    s_in    = 1'b1;
    tick();
    abort   = 1'b0;
    s_valid = 1'b0;
    chk("abort_cnt", bit_cnt, 0);
    chk("abort_busy", busy, 0);
    send_data(4'b0110, 1'b0, 0, 1'b0);
    chk("abort_q_out", q_out, 4'b0110);
    chk("abort_q_valid", q_valid, 1);
    tick();

`ifdef DESER_PARITY_EN
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    chk("par_ok_err", parity_err, 0);
    chk("par_ok_q", q_out, 4'b1011);
    tick();
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    chk("par_bad_err", parity_err, 1);
    chk("par_bad_q", q_out, 4'b1011);
    tick();
`endif

    // randomized run against a word-level reference model
    clr = 1'b1;
    tick();
    clr = 1'b0;
    m_bits.delete();
    m_ord  = 1'b0;
    m_q    = '0;
    m_v    = 1'b0;
    m_ovr  = 1'b0;
    m_perr = 1'b0;
    for (int c = 0; c < 1200; c++) begin
      logic         comp;
      logic [W-1:0] wd;
      logic         p;
      comp = 1'b0;
      wd   = '0;
      p    = 1'b0;
      if (c % 300 == 299) begin
        clr     = 1'b1;
        s_valid = 1'b0;
        abort   = 1'b0;
        q_ready = 1'b0;
        m_bits.delete();
        m_q    = '0;
        m_v    = 1'b0;
        m_ovr  = 1'b0;
        m_perr = 1'b0;
      end else begin
        clr     = 1'b0;
        s_valid = ($urandom_range(99, 0) < 65);
        s_in    = 1'($urandom);
        dir     = 1'($urandom);
        abort   = ($urandom_range(99, 0) < 4);
        q_ready = ($urandom_range(99, 0) < 75);
        if (abort) begin
          m_bits.delete();
        end else if (s_valid) begin
          if (m_bits.size() == 0) m_ord = dir;
          m_bits.push_back(s_in);
          if (m_bits.size() == NB) begin
            comp = 1'b1;
            for (int i = 0; i < W; i++) begin
              if (m_ord) wd[i] = m_bits[i];
              else       wd[W-1-i] = m_bits[i];
            end
            for (int i = 0; i < NB; i++) p = p ^ m_bits[i];
            m_bits.delete();
          end
        end
        if (comp && (!m_v || q_ready)) begin
          m_q    = wd;
          m_v    = 1'b1;
          m_perr = p;
        end else if (comp) begin
          m_ovr = 1'b1;
        end else if (q_ready) begin
          m_v = 1'b0;
        end
      end
      tick();
      chk("rnd_q_valid", q_valid, m_v);
      chk("rnd_q_out", q_out, m_q);
      chk("rnd_bit_cnt", bit_cnt, m_bits.size());
      chk("rnd_busy", busy, m_bits.size() != 0);
      chk("rnd_overrun", overrun, m_ovr);
`ifdef DESER_PARITY_EN
      chk("rnd_parity_err", parity_err, m_perr);
`endif
    end
    clr = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule

`default_nettype wire
